// File: rtl/ysyx_25040101_pkg.sv
// Shared definitions for the LSU: funct3 memory-op encodings, FSM state type,
// default bus timeout and the op legality helper.
package ysyx_25040101_pkg;

  localparam logic [2:0] MEM_B  = 3'b000;
  localparam logic [2:0] MEM_H  = 3'b001;
  localparam logic [2:0] MEM_W  = 3'b010;
  localparam logic [2:0] MEM_BU = 3'b100;
  localparam logic [2:0] MEM_HU = 3'b101;

  localparam int unsigned TIMEOUT_DEFAULT = 255;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_RESP
  } lsu_state_e;

  // Unsigned variants only exist for loads; 011/110/111 are never legal.
  function automatic logic op_is_legal(input logic [2:0] op, input logic we);
    logic legal;
    case (op)
      MEM_B, MEM_H, MEM_W: legal = 1'b1;
      MEM_BU, MEM_HU:      legal = ~we;
      default:             legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/ysyx_25040101_lsu_if.sv
// Data-bus bundle between the LSU (master) and memory (slave).
interface ysyx_25040101_lsu_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        ack;
  logic        err;
  logic [31:0] rdata;

  modport master (output req, we, addr, wdata, wstrb, input ack, err, rdata);
  modport slave  (input req, we, addr, wdata, wstrb, output ack, err, rdata);
endinterface

// File: rtl/ysyx_25040101_lsu_align.sv
// Byte-lane logic: store strobe/data placement and load extract/extend.
module ysyx_25040101_lsu_align
  import ysyx_25040101_pkg::*;
(
  input  logic [2:0]  op_i,
  input  logic        we_i,
  input  logic [1:0]  offset_i,
  input  logic [31:0] store_data_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  wstrb_o,
  output logic [31:0] wdata_o,
  output logic [31:0] load_data_o
);

  logic [4:0]  shamt;
  logic [3:0]  base_strb;
  logic [31:0] rshift;

  assign shamt = {offset_i, 3'b000};

  always_comb begin
    // NOTE: every output gets a default before the case so no latch is inferred.
    base_strb   = 4'b0000;
    load_data_o = '0;
    case (op_i)
      MEM_B:   base_strb = 4'b0001;
      MEM_H:   base_strb = 4'b0011;
      MEM_W:   base_strb = 4'b1111;
      default: base_strb = 4'b0000;
    endcase
    // Lanes beyond byte 3 fall off the word for misaligned accesses.
    wstrb_o = we_i ? (base_strb << offset_i) : 4'b0000;
    wdata_o = store_data_i << shamt;
    rshift  = rdata_i >> shamt;
    case (op_i)
      MEM_B:   load_data_o = {{24{rshift[7]}}, rshift[7:0]};
      MEM_H:   load_data_o = {{16{rshift[15]}}, rshift[15:0]};
      MEM_W:   load_data_o = rshift;
      MEM_BU:  load_data_o = {24'd0, rshift[7:0]};
      MEM_HU:  load_data_o = {16'd0, rshift[15:0]};
      default: load_data_o = '0;
    endcase
  end

endmodule

// File: rtl/ysyx_25040101_lsu.sv
// Load/store unit: one outstanding access, IDLE/REQ/RESP FSM with bus timeout.
// Define YSYX_25040101_LSU_MISALIGN_CHK_EN to fault misaligned H/W accesses.
module ysyx_25040101_lsu
  import ysyx_25040101_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [31:0] alu_result_i,
  input  logic [31:0] store_data_i,
  input  logic [2:0]  mem_op_i,
  input  logic        mem_we_i,
  output logic        resp_valid_o,
  input  logic        resp_ready_i,
  output logic [31:0] resp_data_o,
  output logic        resp_fault_o,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_wdata_o,
  output logic [3:0]  bus_wstrb_o,
  input  logic        bus_ack_i,
  input  logic        bus_err_i,
  input  logic [31:0] bus_rdata_i
);

  localparam logic [7:0] TIMEOUT_Q = 8'(TIMEOUT_CYCLES);

  lsu_state_e  state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] sdata_q, sdata_d;
  logic [2:0]  op_q, op_d;
  logic        we_q, we_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        bus_req_q, bus_req_d;
  logic        resp_valid_q, resp_valid_d;
  logic        resp_fault_q, resp_fault_d;
  logic [31:0] resp_data_q, resp_data_d;

  logic        accept;
  logic        misalign;
  logic        op_fault;
  logic [31:0] load_data;

  assign req_ready_o = (state_q == ST_IDLE) && rst_n_i;
  assign accept      = req_valid_i && req_ready_o;

`ifdef YSYX_25040101_LSU_MISALIGN_CHK_EN
  assign misalign = ((mem_op_i == MEM_H || mem_op_i == MEM_HU) && alu_result_i[0])
                 || ((mem_op_i == MEM_W) && (alu_result_i[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  assign op_fault = !op_is_legal(mem_op_i, mem_we_i) || misalign;

  ysyx_25040101_lsu_align u_align (
    .op_i        (op_q),
    .we_i        (we_q),
    .offset_i    (addr_q[1:0]),
    .store_data_i(sdata_q),
    .rdata_i     (bus_rdata_i),
    .wstrb_o     (bus_wstrb_o),
    .wdata_o     (bus_wdata_o),
    .load_data_o (load_data)
  );

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    sdata_d      = sdata_q;
    op_d         = op_q;
    we_d         = we_q;
    cnt_d        = cnt_q;
    resp_valid_d = resp_valid_q;
    resp_fault_d = resp_fault_q;
    resp_data_d  = resp_data_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          addr_d  = alu_result_i;
          sdata_d = store_data_i;
          op_d    = mem_op_i;
          we_d    = mem_we_i;
          cnt_d   = 8'd1;
          if (op_fault) begin
            state_d      = ST_RESP;
            resp_valid_d = 1'b1;
            resp_fault_d = 1'b1;
            resp_data_d  = '0;
          end else begin
            state_d = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        // An ack in the final counted cycle still completes normally.
        if (bus_ack_i) begin
          state_d      = ST_RESP;
          resp_valid_d = 1'b1;
          resp_fault_d = bus_err_i;
          resp_data_d  = (bus_err_i || we_q) ? '0 : load_data;
        end else if (cnt_q == TIMEOUT_Q) begin
          state_d      = ST_RESP;
          resp_valid_d = 1'b1;
          resp_fault_d = 1'b1;
          resp_data_d  = '0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_RESP: begin
        if (resp_ready_i) begin
          state_d      = ST_IDLE;
          resp_valid_d = 1'b0;
          resp_fault_d = 1'b0;
          resp_data_d  = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    bus_req_d = (state_d == ST_REQ);
  end

  // NOTE: synchronous reset lives inside the clocked block; all state uses <= only.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      sdata_q      <= '0;
      op_q         <= MEM_B;
      we_q         <= 1'b0;
      cnt_q        <= '0;
      bus_req_q    <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_fault_q <= 1'b0;
      resp_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      sdata_q      <= sdata_d;
      op_q         <= op_d;
      we_q         <= we_d;
      cnt_q        <= cnt_d;
      bus_req_q    <= bus_req_d;
      resp_valid_q <= resp_valid_d;
      resp_fault_q <= resp_fault_d;
      resp_data_q  <= resp_data_d;
    end
  end

  assign bus_req_o    = bus_req_q;
  assign bus_we_o     = we_q;
  assign bus_addr_o   = addr_q;
  assign resp_valid_o = resp_valid_q;
  assign resp_fault_o = resp_fault_q;
  assign resp_data_o  = resp_data_q;

endmodule

// File: tb/tb_ysyx_25040101_lsu.sv
// Self-checking bench for ysyx_25040101_lsu: directed vector table, reset
// abandonment sequence, then random accesses against a byte-level model.
module tb_ysyx_25040101_lsu;

  localparam int TMO = 4;
`ifdef YSYX_25040101_LSU_MISALIGN_CHK_EN
  localparam bit MIS_CHK = 1'b1;
`else
  localparam bit MIS_CHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] alu_result = '0;
  logic [31:0] store_data = '0;
  logic [2:0]  mem_op = '0;
  logic        mem_we = 1'b0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_data;
  logic        resp_fault;

  ysyx_25040101_lsu_if bus_if ();

  ysyx_25040101_lsu #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .alu_result_i(alu_result),
    .store_data_i(store_data),
    .mem_op_i    (mem_op),
    .mem_we_i    (mem_we),
    .resp_valid_o(resp_valid),
    .resp_ready_i(resp_ready),
    .resp_data_o (resp_data),
    .resp_fault_o(resp_fault),
    .bus_req_o   (bus_if.req),
    .bus_we_o    (bus_if.we),
    .bus_addr_o  (bus_if.addr),
    .bus_wdata_o (bus_if.wdata),
    .bus_wstrb_o (bus_if.wstrb),
    .bus_ack_i   (bus_if.ack),
    .bus_err_i   (bus_if.err),
    .bus_rdata_i (bus_if.rdata)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model (byte-lane view) ----------------
  function automatic int op_size(input logic [2:0] op);
    case (op)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      3'b010:         return 4;
      default:        return 0;
    endcase
  endfunction

  function automatic bit model_op_fault(input logic [2:0] op, input logic we, input int off);
    bit legal, mis;
    legal = (op == 3'b000 || op == 3'b001 || op == 3'b010) ||
            ((op == 3'b100 || op == 3'b101) && !we);
    mis = MIS_CHK && (((op == 3'b001 || op == 3'b101) && (off % 2 == 1)) ||
                      (op == 3'b010 && off != 0));
    return !legal || mis;
  endfunction

  function automatic logic [3:0] model_wstrb(input logic [2:0] op, input int off);
    logic [3:0] s = 4'b0000;
    for (int i = 0; i < 4; i++)
      if (i >= off && i - off < op_size(op)) s[i] = 1'b1;
    return s;
  endfunction

  function automatic logic [31:0] model_wdata(input logic [31:0] d, input int off);
    logic [31:0] w = '0;
    for (int i = 0; i < 4; i++)
      if (i >= off) w[8*i +: 8] = d[8*(i-off) +: 8];
    return w;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] op, input int off, input logic [31:0] rd);
    longint val = 0;
    int sz = op_size(op);
    for (int i = 0; i < sz; i++)
      if (i + off < 4) val += longint'(rd[8*(i+off) +: 8]) << (8*i);
    if (op == 3'b000 && val >= 128)   val -= 256;
    if (op == 3'b001 && val >= 32768) val -= 65536;
    return val[31:0];
  endfunction

  // ---------------- one complete access ----------------
  task automatic run_txn(input string name, input logic [2:0] op, input logic we,
                         input logic [31:0] addr, input logic [31:0] sdata, input logic [31:0] rdata,
                         input int ack_at, input logic err, input int hold,
                         input logic exp_fault, input logic [31:0] exp_data,
                         input logic [3:0] exp_wstrb, input logic [31:0] exp_wdata, input int exp_reqs);
    int  cyc, reqs;
    bit  done;
    @(negedge clk);
    mem_op = op; mem_we = we; alu_result = addr; store_data = sdata; req_valid = 1'b1;
    check({name, " req_ready"}, 32'(req_ready), 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    cyc = 1; reqs = 0; done = 1'b0;
    while (!done && cyc <= 20) begin
      bus_if.ack = 1'b0; bus_if.err = 1'b0; bus_if.rdata = $urandom;
      if (resp_valid) begin
        done = 1'b1;
      end else begin
        if (bus_if.req) begin
          reqs++;
          if (reqs == 1) begin
            check({name, " bus_addr"}, bus_if.addr, addr);
            check({name, " bus_we"}, 32'(bus_if.we), 32'(we));
            check({name, " bus_wstrb"}, 32'(bus_if.wstrb), 32'(exp_wstrb));
            if (we) check({name, " bus_wdata"}, bus_if.wdata, exp_wdata);
          end
          if (reqs - 1 == ack_at) begin
            bus_if.ack = 1'b1; bus_if.err = err; bus_if.rdata = rdata;
          end
        end
        @(negedge clk);
        cyc++;
      end
    end
    check({name, " latency"}, 32'(cyc), 32'(exp_reqs + 1));
    check({name, " req_cycles"}, 32'(reqs), 32'(exp_reqs));
    check({name, " fault"}, 32'(resp_fault), 32'(exp_fault));
    check({name, " data"}, resp_data, exp_data);
    // Stray bus responses while waiting must not disturb the held result.
    for (int h = 0; h < hold; h++) begin
      bus_if.ack = 1'b1; bus_if.err = 1'b1;
      @(negedge clk);
      check({name, " hold_valid"}, 32'(resp_valid), 32'd1);
      check({name, " hold_data"}, resp_data, exp_data);
      check({name, " hold_fault"}, 32'(resp_fault), 32'(exp_fault));
      check({name, " hold_ready"}, 32'(req_ready), 32'd0);
    end
    bus_if.ack = 1'b0; bus_if.err = 1'b0;
    resp_ready = 1'b1;
    check({name, " no_accept_in_resp"}, 32'(req_ready), 32'd0);
    @(negedge clk);
    resp_ready = 1'b0;
    check({name, " resp_drop"}, 32'(resp_valid), 32'd0);
    check({name, " back_idle"}, 32'(req_ready), 32'd1);
  endtask

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic        we;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic [31:0] rdata;
    int          ack_at;
    logic        err;
    int          hold;
    logic        exp_fault;
    logic [31:0] exp_data;
    logic [3:0]  exp_wstrb;
    logic [31:0] exp_wdata;
    int          exp_reqs;
  } vec_t;

  vec_t vecs[14];

  initial begin
    logic [2:0] op_pool [10];
    vecs[0]  = '{"lb_sext",    3'b000, 1'b0, 32'h8000_0003, 32'h0,         32'h80FF_FFFF, 0, 1'b0, 5, 1'b0, 32'hFFFF_FF80, 4'b0000, 32'h0, 1};
    vecs[1]  = '{"sh_off2",    3'b001, 1'b1, 32'h8000_0002, 32'h1234_ABCD, 32'h0,         0, 1'b0, 0, 1'b0, 32'h0,         4'b1100, 32'hABCD_0000, 1};
    vecs[2]  = '{"lw_timeout", 3'b010, 1'b0, 32'h0000_0100, 32'h0,         32'h1111_1111, 9, 1'b0, 1, 1'b1, 32'h0,         4'b0000, 32'h0, TMO};
    vecs[3]  = '{"lw_ack_last",3'b010, 1'b0, 32'h0000_0100, 32'h0,         32'hDEAD_BEEF, 3, 1'b0, 0, 1'b0, 32'hDEAD_BEEF, 4'b0000, 32'h0, TMO};
    if (MIS_CHK)
      vecs[4] = '{"lw_mis",    3'b010, 1'b0, 32'h1000_0001, 32'h0,         32'hAABB_CCDD, 0, 1'b0, 0, 1'b1, 32'h0,         4'b0000, 32'h0, 0};
    else
      vecs[4] = '{"lw_mis",    3'b010, 1'b0, 32'h1000_0001, 32'h0,         32'hAABB_CCDD, 0, 1'b0, 0, 1'b0, 32'h00AA_BBCC, 4'b0000, 32'h0, 1};
    vecs[5]  = '{"lbu",        3'b100, 1'b0, 32'h0000_0002, 32'h0,         32'h00F0_0000, 1, 1'b0, 0, 1'b0, 32'h0000_00F0, 4'b0000, 32'h0, 2};
    vecs[6]  = '{"lh_sext",    3'b001, 1'b0, 32'h0000_0000, 32'h0,         32'h0000_8001, 0, 1'b0, 0, 1'b0, 32'hFFFF_8001, 4'b0000, 32'h0, 1};
    vecs[7]  = '{"lhu",        3'b101, 1'b0, 32'h0000_0002, 32'h0,         32'h9ABC_0000, 2, 1'b0, 0, 1'b0, 32'h0000_9ABC, 4'b0000, 32'h0, 3};
    vecs[8]  = '{"bad_op011",  3'b011, 1'b0, 32'h0000_0000, 32'h0,         32'h0,         0, 1'b0, 0, 1'b1, 32'h0,         4'b0000, 32'h0, 0};
    vecs[9]  = '{"store_bu",   3'b100, 1'b1, 32'h0000_0000, 32'h55,        32'h0,         0, 1'b0, 2, 1'b1, 32'h0,         4'b0000, 32'h0, 0};
    vecs[10] = '{"bus_err",    3'b010, 1'b0, 32'h0000_0200, 32'h0,         32'hFFFF_FFFF, 1, 1'b1, 0, 1'b1, 32'h0,         4'b0000, 32'h0, 2};
    vecs[11] = '{"sb_off1",    3'b000, 1'b1, 32'h0000_0001, 32'h0000_00A5, 32'h0,         0, 1'b0, 5, 1'b0, 32'h0,         4'b0010, 32'h0000_A500, 1};
    if (MIS_CHK)
      vecs[12] = '{"lh_off3",  3'b001, 1'b0, 32'h0000_0003, 32'h0,         32'h8011_2233, 0, 1'b0, 0, 1'b1, 32'h0,         4'b0000, 32'h0, 0};
    else
      vecs[12] = '{"lh_off3",  3'b001, 1'b0, 32'h0000_0003, 32'h0,         32'h8011_2233, 0, 1'b0, 0, 1'b0, 32'h0000_0080, 4'b0000, 32'h0, 1};
    vecs[13] = '{"sw",         3'b010, 1'b1, 32'h0000_0010, 32'hCAFE_F00D, 32'h0,         0, 1'b0, 0, 1'b0, 32'h0,         4'b1111, 32'hCAFE_F00D, 1};

    bus_if.ack = 1'b0; bus_if.err = 1'b0; bus_if.rdata = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst req_ready", 32'(req_ready), 32'd0);
    check("rst bus_req", 32'(bus_if.req), 32'd0);
    check("rst bus_we", 32'(bus_if.we), 32'd0);
    check("rst bus_addr", bus_if.addr, 32'd0);
    check("rst bus_wdata", bus_if.wdata, 32'd0);
    check("rst bus_wstrb", 32'(bus_if.wstrb), 32'd0);
    check("rst resp_valid", 32'(resp_valid), 32'd0);
    check("rst resp_fault", 32'(resp_fault), 32'd0);
    check("rst resp_data", resp_data, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst req_ready", 32'(req_ready), 32'd1);

    for (int i = 0; i < 14; i++)
      run_txn(vecs[i].name, vecs[i].op, vecs[i].we, vecs[i].addr, vecs[i].sdata, vecs[i].rdata,
              vecs[i].ack_at, vecs[i].err, vecs[i].hold, vecs[i].exp_fault, vecs[i].exp_data,
              vecs[i].exp_wstrb, vecs[i].exp_wdata, vecs[i].exp_reqs);

    // Reset while a load is on the bus; the late ack must be ignored.
    @(negedge clk);
    mem_op = 3'b010; mem_we = 1'b0; alu_result = 32'h0000_0040; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    check("abort in_req", 32'(bus_if.req), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort bus_req", 32'(bus_if.req), 32'd0);
    check("abort resp_valid", 32'(resp_valid), 32'd0);
    check("abort bus_addr", bus_if.addr, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    bus_if.ack = 1'b1; bus_if.rdata = 32'h1234_5678;
    @(negedge clk);
    bus_if.ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("late_ack resp_valid", 32'(resp_valid), 32'd0);
      check("late_ack bus_req", 32'(bus_if.req), 32'd0);
      check("late_ack req_ready", 32'(req_ready), 32'd1);
      @(negedge clk);
    end

    // Random accesses against the byte-lane model.
    op_pool = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b000, 3'b001, 3'b010, 3'b011, 3'b111};
    for (int n = 0; n < 60; n++) begin
      logic [2:0]  op;
      logic        we, err, fault;
      logic [31:0] addr, sdata, rdata, data;
      int          ack_at, off, reqs;
      op     = op_pool[$urandom_range(0, 9)];
      we     = 1'($urandom_range(0, 1));
      addr   = $urandom;
      off    = int'(addr[1:0]);
      sdata  = $urandom;
      rdata  = $urandom;
      ack_at = $urandom_range(0, 5);
      err    = ($urandom_range(0, 5) == 0);
      if (model_op_fault(op, we, off)) begin
        fault = 1'b1; reqs = 0;
      end else if (ack_at < TMO) begin
        fault = err; reqs = ack_at + 1;
      end else begin
        fault = 1'b1; reqs = TMO;
      end
      data = (fault || we) ? 32'h0 : model_load(op, off, rdata);
      run_txn("rand", op, we, addr, sdata, rdata, ack_at, err, $urandom_range(0, 2),
              fault, data, we ? model_wstrb(op, off) : 4'b0000, model_wdata(sdata, off), reqs);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/ysyx_25040101_lsu.md
YSYX_25040101_LSU -- requirements
Module: ysyx_25040101_lsu

Interface
REQ-001 SHALL have parameter: TIMEOUT_CYCLES, 255, bus cycles in REQ before the access is abandoned with fault (range 1..255).
REQ-002 SHALL have port: clk_i  in  1  single clock, all state on rising edge.
REQ-003 SHALL have port: rst_n_i  in  1  reset, synchronous, active-low.
REQ-004 SHALL have port: req_valid_i  in  1  execute stage offers access.
REQ-005 SHALL have port: req_ready_o  out  1  LSU accepts access.
REQ-006 SHALL have port: alu_result_i  in  32  effective byte address from ALU.
REQ-007 SHALL have port: store_data_i  in  32  rs2 data.
REQ-008 SHALL have port: mem_op_i  in  3  funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-009 SHALL have port: mem_we_i  in  1  1 = store, 0 = load.
REQ-010 SHALL have port: resp_valid_o  out  1  result available.
REQ-011 SHALL have port: resp_ready_i  in  1  writeback consumes result.
REQ-012 SHALL have port: resp_data_o  out  32  extended load data; 0 for stores and faults.
REQ-013 SHALL have port: resp_fault_o  out  1  access fault (bad op, misalign, bus error, timeout).
REQ-014 SHALL have ports: bus_req_o out 1, bus_we_o out 1, bus_addr_o out 32, bus_wdata_o out 32, bus_wstrb_o out 4, bus_ack_i in 1, bus_err_i in 1, bus_rdata_i in 32.

Function
REQ-015 SHALL implement FSM IDLE, REQ, RESP; req_ready_o = (state==IDLE) and rst_n_i high.
REQ-016 SHALL accept on req_valid_i & req_ready_o, registering address, offset alu_result_i[1:0], op, we, store data.
REQ-017 SHALL go IDLE->REQ on accept of a legal op; IDLE->RESP with fault and no bus cycle for mem_op_i in {011,110,111}, or BU/HU with mem_we_i=1.
REQ-018 SHALL in REQ hold bus_req_o=1 with bus_addr_o = registered address, stable until ack or timeout.
REQ-019 SHALL drive bus_wstrb_o = (B:0001, H:0011, W:1111) << offset, truncated to 4 bits; 0000 for loads.
REQ-020 SHALL drive bus_wdata_o = store data shifted left by 8*offset, truncated to 32 bits.
REQ-021 SHALL on bus_ack_i in REQ go to RESP next edge; bus_req_o low from that edge.
REQ-022 SHALL on load ack compute v = bus_rdata_i >> 8*offset; B/H sign-extend v[7:0]/v[15:0]; BU/HU zero-extend; W passes v.
REQ-023 SHALL treat bus_err_i with bus_ack_i as fault, resp_data_o = 0.
REQ-024 SHALL count REQ cycles from 1; at count==TIMEOUT_CYCLES without ack go to RESP with fault; ack in that same cycle wins (normal completion).
REQ-025 SHALL hold resp_valid_o, resp_data_o, resp_fault_o stable in RESP until resp_ready_i, then go IDLE; no new accept in that cycle.
REQ-026 SHALL give minimum latency accept->resp_valid_o of 2 cycles (ack in first REQ cycle), 1 cycle for faulted ops.
REQ-027 SHALL ignore bus_ack_i/bus_err_i outside REQ.

Reset
REQ-028 SHALL, with rst_n_i low at an edge, enter IDLE, clear counter and captured fields; bus_req_o, bus_we_o, resp_valid_o, resp_fault_o = 0; bus_addr_o, bus_wdata_o, resp_data_o = 0; bus_wstrb_o = 0000.
REQ-029 SHALL abandon an in-flight access on reset without waiting for ack; a late ack after reset is ignored.

Configuration
REQ-030 SHALL, with YSYX_25040101_LSU_MISALIGN_CHK_EN defined, send H/HU/SH with offset[0]=1 and W with offset!=00 IDLE->RESP with fault, no bus cycle.
REQ-031 SHALL, without the macro, issue misaligned accesses on the bus per REQ-019/020/022 (truncated lanes, no fault).

Structure
REQ-032 SHALL place mem_op encodings, FSM state type and default TIMEOUT_CYCLES in package ysyx_25040101_pkg.
REQ-033 SHALL put lane logic (wstrb, wdata shift, load extract/extend) in combinational sub-module ysyx_25040101_lsu_align.

Verification
REQ-034 LB, addr 0x8000_0003, rdata 0x80FF_FFFF, ack first REQ cycle -> resp_data_o 0xFFFF_FF80, fault 0, valid 2 cycles after accept.
REQ-035 SH, addr 0x8000_0002, data 0x1234_ABCD -> bus_wstrb_o 1100, bus_wdata_o 0xABCD_0000, resp_data_o 0.
REQ-036 LW, TIMEOUT_CYCLES=4, no ack -> bus_req_o high exactly 4 cycles, then resp_fault_o 1; ack in 4th cycle -> no fault.
REQ-037 LW addr 0x...01: with macro -> fault, bus_req_o never high; without -> bus cycle, rdata 0xAABBCCDD gives 0x00AABBCC.
REQ-038 rst_n_i low during REQ, ack 2 cycles later -> IDLE, bus_req_o 0, no resp_valid_o; resp_ready_i low 5 cycles -> resp outputs held, req_ready_o 0.
